fu_scheduler: RTL and testbench
===============================

# fu_scheduler

Tracks the occupancy of the three functional units fed by the reservation station and drives its `FU1_ready`/`FU2_ready`/`FU3_ready` inputs. Sequences each issued op through execution. Arbitrates the single data-memory port among FUs holding load/store ops, using round-robin. Signals completion per FU so writeback and wakeup logic can retire results.

## Interface
Parameters:
- `ALU_LATENCY`, default 1: execute cycles per op (address calculation for LS ops); legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 resets immediately).
- `issue_FU1_valid`, `issue_FU2_valid`, `issue_FU3_valid`  in  1 each  new op issued to FU1/2/3 this cycle.
- `issue_is_LS`  in  3  bit i = op issued to FU i+1 is load/store; sampled only with the matching valid.
- `mem_ack`  in  1  memory finished the granted access.
- `FU1_ready`, `FU2_ready`, `FU3_ready`  out  1 each  FU in IDLE.
- `mem_start`  out  1  one-cycle pulse: new memory access begins.
- `mem_fu_sel`  out  2  FU index (0..2) owning the memory port; holds its value until the next grant.
- `mem_busy`  out  1  memory access outstanding.
- `fu_complete`  out  3  bit i pulses for one cycle when FU i+1 finishes.
- `err_sticky`  out  1  protocol violation seen; cleared only by reset.

## Operation
- Each FU has its own FSM with states IDLE, EXEC, MEM_WAIT, MEM_BUSY and DONE, plus a 4-bit counter.
- IDLE + issue valid → EXEC; counter loaded with ALU_LATENCY-1; LS flag latched.
- EXEC with counter 0: non-LS → DONE; LS → MEM_WAIT. Otherwise the counter decrements.
- MEM_WAIT: stay until granted → MEM_BUSY.
- MEM_BUSY + `mem_ack` → DONE.
- DONE → IDLE unconditionally; `fu_complete[i]` is high exactly while in DONE.
- `FUi_ready` = (state == IDLE), decoded from registered state.
- Arbiter:
  - When `mem_busy`=0 and at least one FU is in MEM_WAIT, grant the first waiting FU scanning from `rr_ptr` upward, mod 3.
  - Next edge: winner → MEM_BUSY, `mem_busy`←1, `mem_start`←1, `mem_fu_sel`←winner, `rr_ptr`←(winner+1) mod 3.
  - Exactly one grant per arbitration cycle.
- `mem_ack` while MEM_BUSY → `mem_busy`←0 at the next edge. The port can be re-granted in the cycle after the ack, never in the ack cycle.
- Errors set `err_sticky`; the offending event has no other effect:
  - issue valid to an FU not in IDLE;
  - `mem_ack` while `mem_busy`=0.
- Reset (async, mid-operation too):
  - all FSMs → IDLE, `rr_ptr`=0, `mem_busy`=0, `mem_start`=0, `mem_fu_sel`=0, `fu_complete`=0, `err_sticky`=0;
  - ready outputs read 1 during and after reset;
  - in-flight ops are dropped without a completion pulse.

## Timing
- Non-LS op issued in cycle t:
  - EXEC cycles t+1..t+ALU_LATENCY;
  - `fu_complete` in cycle t+ALU_LATENCY+1;
  - ready again at t+ALU_LATENCY+2.
- LS op issued in cycle t:
  - MEM_WAIT from t+ALU_LATENCY+1;
  - with the port free, grant decided in that cycle; `mem_start` and MEM_BUSY in the next cycle (t+ALU_LATENCY+2);
  - `mem_ack` is legal in the `mem_start` cycle (zero-wait memory); ack in cycle a → `fu_complete` in a+1.
- Ready is low from the cycle after issue through the DONE cycle inclusive.
- `mem_start` is never high two cycles in a row.

## Test plan
- Reset: drive `reset`=0 mid-sequence → all ready=1, `mem_busy`=0, `fu_complete`=000, `err_sticky`=0 immediately. Release → FSMs idle.
- ALU op, ALU_LATENCY=1: issue FU2 (non-LS) at cycle 0 → `FU2_ready`=0 in cycles 1–2, `fu_complete`=010 in cycle 2, `FU2_ready`=1 in cycle 3; no `mem_start`.
- Three LS ops issued together at cycle 0, `mem_ack` on each `mem_start` cycle → `mem_start` in cycles 3, 5, 7 with `mem_fu_sel`=0, 1, 2; `fu_complete` 001/010/100 in cycles 4, 6, 8.
- Round-robin fairness: `rr_ptr`=1 with FU1 and FU3 both waiting → FU3 (index 2) granted first, then FU1 (index 0).
- Memory stall: one LS grant with `mem_ack` held low 5 cycles → `mem_busy`=1 throughout, second waiting FU not granted until the cycle after the ack.
- Errors:
  - issue to FU1 while FU1 is in EXEC → `err_sticky`=1, FU1 timing unchanged;
  - `mem_ack` while idle → `err_sticky`=1;
  - both clear only on `reset`=0.

Source files
------------

// File: rtl/fu_scheduler.sv
// Per-FU occupancy/sequencing FSMs plus a round-robin arbiter for the shared data-memory port.
// Grant decided combinationally from registered state; grant, mem_start and FU transitions take effect at the next edge.
module fu_scheduler #(
  parameter int ALU_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_FU1_valid,
  input  logic       issue_FU2_valid,
  input  logic       issue_FU3_valid,
  input  logic [2:0] issue_is_LS,
  input  logic       mem_ack,
  output logic       FU1_ready,
  output logic       FU2_ready,
  output logic       FU3_ready,
  output logic       mem_start,
  output logic [1:0] mem_fu_sel,
  output logic       mem_busy,
  output logic [2:0] fu_complete,
  output logic       err_sticky
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MEM_WAIT, S_MEM_BUSY, S_DONE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LATENCY - 1);

  state_t     state_q [3];
  state_t     state_d [3];
  logic [3:0] cnt_q   [3];
  logic [3:0] cnt_d   [3];
  logic [2:0] ls_q, ls_d;
  logic       mem_busy_q, mem_busy_d;
  logic       mem_start_q, mem_start_d;
  logic [1:0] mem_fu_sel_q, mem_fu_sel_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic       err_q, err_d;

  logic [2:0] issue_v;
  logic [2:0] waiting;
  logic       grant_vld;
  logic [1:0] grant_idx;
  logic [1:0] cand0, cand1, cand2;
  logic       issue_err;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign issue_v = {issue_FU3_valid, issue_FU2_valid, issue_FU1_valid};

  // Round-robin scan: rr_ptr first, then the next two indices mod 3.
  always_comb begin
    for (int i = 0; i < 3; i++) waiting[i] = (state_q[i] == S_MEM_WAIT);
    cand0     = rr_ptr_q;
    cand1     = inc3(cand0);
    cand2     = inc3(cand1);
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    if (!mem_busy_q) begin
      if (waiting[cand0]) begin
        grant_vld = 1'b1;
        grant_idx = cand0;
      end else if (waiting[cand1]) begin
        grant_vld = 1'b1;
        grant_idx = cand1;
      end else if (waiting[cand2]) begin
        grant_vld = 1'b1;
        grant_idx = cand2;
      end
    end
  end

  always_comb begin
    ls_d      = ls_q;
    issue_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (issue_v[i] && state_q[i] != S_IDLE) issue_err = 1'b1;
      case (state_q[i])
        S_IDLE: if (issue_v[i]) begin
          state_d[i] = S_EXEC;
          cnt_d[i]   = LAT_M1;
          ls_d[i]    = issue_is_LS[i];
        end
        S_EXEC: begin
          if (cnt_q[i] == 4'd0) state_d[i] = ls_q[i] ? S_MEM_WAIT : S_DONE;
          else                  cnt_d[i]   = cnt_q[i] - 4'd1;
        end
        S_MEM_WAIT: if (grant_vld && grant_idx == 2'(i)) state_d[i] = S_MEM_BUSY;
        S_MEM_BUSY: if (mem_ack) state_d[i] = S_DONE;
        S_DONE:     state_d[i] = S_IDLE;
        default:    state_d[i] = S_IDLE;
      endcase
    end

    mem_start_d  = grant_vld;
    mem_fu_sel_d = grant_vld ? grant_idx : mem_fu_sel_q;
    rr_ptr_d     = grant_vld ? inc3(grant_idx) : rr_ptr_q;
    mem_busy_d   = mem_busy_q;
    if (grant_vld)                mem_busy_d = 1'b1;
    else if (mem_ack && mem_busy_q) mem_busy_d = 1'b0;
    err_d = err_q | issue_err | (mem_ack & ~mem_busy_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= 4'd0;
      end
      ls_q         <= 3'b000;
      mem_busy_q   <= 1'b0;
      mem_start_q  <= 1'b0;
      mem_fu_sel_q <= 2'd0;
      rr_ptr_q     <= 2'd0;
      err_q        <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ls_q         <= ls_d;
      mem_busy_q   <= mem_busy_d;
      mem_start_q  <= mem_start_d;
      mem_fu_sel_q <= mem_fu_sel_d;
      rr_ptr_q     <= rr_ptr_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    FU1_ready = (state_q[0] == S_IDLE);
    FU2_ready = (state_q[1] == S_IDLE);
    FU3_ready = (state_q[2] == S_IDLE);
    for (int i = 0; i < 3; i++) fu_complete[i] = (state_q[i] == S_DONE);
    mem_start  = mem_start_q;
    mem_fu_sel = mem_fu_sel_q;
    mem_busy   = mem_busy_q;
    err_sticky = err_q;
  end

endmodule

// File: tb/tb_fu_scheduler.sv
// Cycle tables for fu_scheduler plus a monitor that pops expected grant indices and completions from queues.
module tb_fu_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       v1 = 0, v2 = 0, v3 = 0;
  logic [2:0] is_ls = 3'b000;
  logic       mem_ack = 1'b0;
  logic       r1, r2, r3, mem_start, mem_busy, err_sticky;
  logic [1:0] mem_fu_sel;
  logic [2:0] fu_complete;

  int pass_cnt = 0;
  int total_cnt = 0;

  fu_scheduler #(.ALU_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .issue_FU1_valid(v1), .issue_FU2_valid(v2), .issue_FU3_valid(v3),
    .issue_is_LS(is_ls), .mem_ack(mem_ack),
    .FU1_ready(r1), .FU2_ready(r2), .FU3_ready(r3),
    .mem_start(mem_start), .mem_fu_sel(mem_fu_sel), .mem_busy(mem_busy),
    .fu_complete(fu_complete), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] v;
    logic [2:0] ls;
    logic       ack;
    logic [2:0] rdy;
    logic       st;
    logic [1:0] sel;
    logic       busy;
    logic [2:0] cmp;
    logic       err;
  } vec_t;

  vec_t       tbl[$];
  logic [1:0] sel_q[$];
  logic [2:0] cmp_q[$];

  task automatic chk(input bit ok, input string msg);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s", msg);
  endtask

  task automatic add(input logic [2:0] v, input logic [2:0] ls, input logic ack,
                     input logic [2:0] rdy, input logic st, input logic [1:0] sel,
                     input logic busy, input logic [2:0] cmp, input logic err);
    vec_t e;
    e.v = v; e.ls = ls; e.ack = ack; e.rdy = rdy; e.st = st;
    e.sel = sel; e.busy = busy; e.cmp = cmp; e.err = err;
    tbl.push_back(e);
  endtask

  function automatic logic [10:0] act_bits();
    return {r3, r2, r1, mem_start, mem_fu_sel, mem_busy, fu_complete, err_sticky};
  endfunction

  task automatic run(input string name);
    logic [10:0] exp_b, act_b;
    for (int k = 0; k < tbl.size(); k++) begin
      @(posedge clk);
      #1;
      {v3, v2, v1} = tbl[k].v;
      is_ls        = tbl[k].ls;
      mem_ack      = tbl[k].ack;
      @(negedge clk);
      exp_b = {tbl[k].rdy, tbl[k].st, tbl[k].sel, tbl[k].busy, tbl[k].cmp, tbl[k].err};
      act_b = act_bits();
      chk(act_b == exp_b,
          $sformatf("%s cycle %0d: got rdy/st/sel/busy/cmp/err=%b_%b_%0d_%b_%b_%b required %b_%b_%0d_%b_%b_%b",
                    name, k, act_b[10:8], act_b[7], act_b[6:5], act_b[4], act_b[3:1], act_b[0],
                    exp_b[10:8], exp_b[7], exp_b[6:5], exp_b[4], exp_b[3:1], exp_b[0]));
    end
    tbl.delete();
  endtask

  // Reset is asserted away from the clock edge and checked before any edge arrives.
  task automatic do_reset(input string name);
    logic [10:0] act_b;
    @(negedge clk);
    reset = 1'b0;
    {v3, v2, v1} = 3'b000; is_ls = 3'b000; mem_ack = 1'b0;
    #1;
    act_b = act_bits();
    chk(act_b == 11'b111_0_00_0_000_0,
        $sformatf("%s reset state: got %b required %b", name, act_b, 11'b111_0_00_0_000_0));
    sel_q.delete();
    cmp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (mem_start) begin
        if (sel_q.size() == 0) chk(1'b0, $sformatf("grant: unexpected mem_start sel=%0d", mem_fu_sel));
        else begin
          logic [1:0] e;
          e = sel_q.pop_front();
          chk(mem_fu_sel == e, $sformatf("grant order: got sel=%0d required %0d", mem_fu_sel, e));
        end
      end
      if (|fu_complete) begin
        if (cmp_q.size() == 0) chk(1'b0, $sformatf("completion: unexpected fu_complete=%b", fu_complete));
        else begin
          logic [2:0] e;
          e = cmp_q.pop_front();
          chk(fu_complete == e, $sformatf("completion order: got %b required %b", fu_complete, e));
        end
      end
    end
  end

  initial begin
    do_reset("initial");

    // Non-LS op on FU2.
    cmp_q.push_back(3'b010);
    add(3'b010,3'b000,0, 3'b111,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,0, 3'b101,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,0, 3'b101,0,2'd0,0,3'b010,0);
    add(3'b000,3'b000,0, 3'b111,0,2'd0,0,3'b000,0);
    run("alu_fu2");

    // Three LS ops together, zero-wait memory.
    do_reset("pre_ls3");
    sel_q.push_back(2'd0); sel_q.push_back(2'd1); sel_q.push_back(2'd2);
    cmp_q.push_back(3'b001); cmp_q.push_back(3'b010); cmp_q.push_back(3'b100);
    add(3'b111,3'b111,0, 3'b111,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,0, 3'b000,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,0, 3'b000,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,1, 3'b000,1,2'd0,1,3'b000,0);
    add(3'b000,3'b000,0, 3'b000,0,2'd0,0,3'b001,0);
    add(3'b000,3'b000,1, 3'b001,1,2'd1,1,3'b000,0);
    add(3'b000,3'b000,0, 3'b001,0,2'd1,0,3'b010,0);
    add(3'b000,3'b000,1, 3'b011,1,2'd2,1,3'b000,0);
    add(3'b000,3'b000,0, 3'b011,0,2'd2,0,3'b100,0);
    add(3'b000,3'b000,0, 3'b111,0,2'd2,0,3'b000,0);
    run("ls3");

    // rr_ptr advanced to 1, then FU1 and FU3 wait together: FU3 wins first.
    do_reset("pre_rr");
    sel_q.push_back(2'd0); sel_q.push_back(2'd2); sel_q.push_back(2'd0);
    cmp_q.push_back(3'b001); cmp_q.push_back(3'b100); cmp_q.push_back(3'b001);
    add(3'b001,3'b001,0, 3'b111,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,0, 3'b110,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,0, 3'b110,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,1, 3'b110,1,2'd0,1,3'b000,0);
    add(3'b000,3'b000,0, 3'b110,0,2'd0,0,3'b001,0);
    add(3'b101,3'b101,0, 3'b111,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,0, 3'b010,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,0, 3'b010,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,1, 3'b010,1,2'd2,1,3'b000,0);
    add(3'b000,3'b000,0, 3'b010,0,2'd2,0,3'b100,0);
    add(3'b000,3'b000,1, 3'b110,1,2'd0,1,3'b000,0);
    add(3'b000,3'b000,0, 3'b110,0,2'd0,0,3'b001,0);
    add(3'b000,3'b000,0, 3'b111,0,2'd0,0,3'b000,0);
    run("round_robin");

    // Memory stall: ack held low five cycles, second waiter granted only after the ack.
    do_reset("pre_stall");
    sel_q.push_back(2'd0); sel_q.push_back(2'd1);
    cmp_q.push_back(3'b001); cmp_q.push_back(3'b010);
    add(3'b011,3'b011,0, 3'b111,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,0, 3'b100,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,0, 3'b100,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,0, 3'b100,1,2'd0,1,3'b000,0);
    for (int k = 0; k < 4; k++) add(3'b000,3'b000,0, 3'b100,0,2'd0,1,3'b000,0);
    add(3'b000,3'b000,1, 3'b100,0,2'd0,1,3'b000,0);
    add(3'b000,3'b000,0, 3'b100,0,2'd0,0,3'b001,0);
    add(3'b000,3'b000,1, 3'b101,1,2'd1,1,3'b000,0);
    add(3'b000,3'b000,0, 3'b101,0,2'd1,0,3'b010,0);
    add(3'b000,3'b000,0, 3'b111,0,2'd1,0,3'b000,0);
    run("mem_stall");

    // Issue to a busy FU1: error latched, FU1 timing untouched.
    do_reset("pre_err_issue");
    cmp_q.push_back(3'b001);
    add(3'b001,3'b000,0, 3'b111,0,2'd0,0,3'b000,0);
    add(3'b001,3'b000,0, 3'b110,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,0, 3'b110,0,2'd0,0,3'b001,1);
    add(3'b000,3'b000,0, 3'b111,0,2'd0,0,3'b000,1);
    add(3'b000,3'b000,0, 3'b111,0,2'd0,0,3'b000,1);
    run("err_issue_busy");

    // Stray mem_ack with the port idle.
    do_reset("err_clear1");
    add(3'b000,3'b000,1, 3'b111,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,0, 3'b111,0,2'd0,0,3'b000,1);
    add(3'b000,3'b000,0, 3'b111,0,2'd0,0,3'b000,1);
    run("err_stray_ack");
    do_reset("err_clear2");

    // Reset in the middle of a memory access drops all in-flight ops silently.
    sel_q.push_back(2'd0);
    add(3'b111,3'b111,0, 3'b111,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,0, 3'b000,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,0, 3'b000,0,2'd0,0,3'b000,0);
    add(3'b000,3'b000,0, 3'b000,1,2'd0,1,3'b000,0);
    run("pre_midreset");
    do_reset("mid_op");
    for (int k = 0; k < 4; k++) add(3'b000,3'b000,0, 3'b111,0,2'd0,0,3'b000,0);
    run("post_midreset");

    chk(sel_q.size() == 0 && cmp_q.size() == 0,
        $sformatf("scoreboard drain: %0d grants and %0d completions still expected", sel_q.size(), cmp_q.size()));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
